mcycle_ctrl: RTL and testbench
==============================

// Module: mcycle_ctrl
// PURPOSE
//  Moore FSM control unit for the multi-cycle MIPS-subset CPU. Sequences the shared ALU, PC, IR,
//  register file, memory port and immediate extender (drives its ext_op) over FETCH..WB states.
//  Waits on a memory ready handshake. Counts retired instructions and flags illegal opcodes.
// PARAMETERS
//  CNT_W            32  width of retired-instruction counter (wraps modulo 2^CNT_W)
//  HALT_ON_ILLEGAL   1  1: illegal opcode -> HALT until reset; 0: skip it and return to FETCH
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst_n       in   1      synchronous active-low reset (sampled on rising clk edge)
//  opcode      in   6      IR[31:26], valid from DECODE onward
//  funct       in   6      IR[5:0]
//  zero        in   1      ALU zero flag (combinational, same cycle)
//  mem_rdy     in   1      memory ready; completes current mem_rd/mem_wr access this cycle
//  mem_rd      out  1      memory read request (FETCH, MEM_RD)
//  mem_wr      out  1      memory write request (MEM_WR)
//  pc_wr       out  1      PC load strobe
//  pc_src      out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target
//  ir_wr       out  1      IR load strobe
//  ext_op      out  1      extender mode: 0 zero-extend, 1 sign-extend
//  alu_src_a   out  1      0 PC, 1 rs
//  alu_src_b   out  2      00 rt, 01 const 4, 10 imm32, 11 imm32<<2
//  alu_op      out  3      000 ADD, 001 SUB, 010 OR, 011 LUI (imm<<16)
//  reg_wr      out  1      register-file write strobe
//  reg_dst     out  1      0 rt, 1 rd
//  mem_to_reg  out  1      0 ALUOut, 1 MDR
//  illegal     out  1      sticky illegal-opcode flag
//  instr_cnt   out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Decode: R=000000 (funct 100001 addu, 100011 subu), addiu 001001, ori 001101, lui 001111,
//   lw 100011, sw 101011, beq 000100, j 000010. Any other opcode or R-funct is illegal.
//  States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM,
//   BRANCH, JUMP, HALT. Outputs are pure decode of state (+opcode/funct/zero/mem_rdy).
//  Default for every output not listed below: 0.
//  FETCH: mem_rd=1, alu_src_b=01, ADD; when mem_rdy: pc_wr=1, ir_wr=1, pc_src=00, ->DECODE;
//   else stay, no strobes.
//  DECODE: alu_src_b=11, ADD, ext_op=1 (branch target into ALUOut). Next: R->EXEC_R,
//   addiu/ori/lui->EXEC_I, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP, illegal->see below.
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_op ADD(addu)/SUB(subu) -> WB_R.
//  EXEC_I: alu_src_a=1, alu_src_b=10; addiu ext_op=1 ADD; ori ext_op=0 OR; lui ext_op=0 LUI -> WB_I.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, ADD -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD: mem_rd=1; stay until mem_rdy, then ->WB_MEM.
//  MEM_WR: mem_wr=1 held until mem_rdy; on mem_rdy retire, ->FETCH.
//  WB_R: reg_wr=1, reg_dst=1. WB_I: reg_wr=1, reg_dst=0. WB_MEM: reg_wr=1, mem_to_reg=1. All ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_wr=zero -> FETCH.
//  JUMP: pc_wr=1, pc_src=10 -> FETCH.
//  Retire (instr_cnt+1, wraps to 0) on the cycle leaving WB_R/WB_I/WB_MEM/BRANCH/JUMP, or MEM_WR
//   with mem_rdy. Cycles with mem_rdy=1: R/I-ALU 4, sw 4, lw 5, beq 3, j 3; +1 per wait cycle.
//  Illegal in DECODE: illegal<=1 (sticky until reset); HALT_ON_ILLEGAL=1 -> HALT (all strobes 0,
//   never leaves); =0 -> FETCH, not counted as retired.
//  Reset (rst_n=0 at edge, any state incl. mid-wait): state<=FETCH, illegal<=0, instr_cnt<=0;
//   reset has priority over every transition. Note: FETCH drives mem_rd=1 combinationally, so
//   mem_rd is 1 (all other strobes 0) in the cycle after reset is released.
//  mem_rdy outside FETCH/MEM_RD/MEM_WR is ignored.
// TESTING
//  Reset mid-MEM_RD with mem_rdy=0 -> next cycle FETCH, instr_cnt=0, reg_wr never pulses.
//  addu then ori, mem_rdy=1 -> 4 cycles each; ext_op=0 in ori EXEC_I; WB_R reg_dst=1; instr_cnt=2.
//  lw with mem_rdy low 3 cycles in MEM_RD -> mem_rd held 3+1 cycles, WB_MEM mem_to_reg=1, total 8.
//  beq zero=1 vs zero=0 -> pc_wr=1,pc_src=01 only when zero=1; 3 cycles; both retire.
//  opcode 111111, HALT_ON_ILLEGAL=1 -> illegal=1, HALT, no strobes for 20 cycles; =0 -> FETCH.
//  CNT_W=4, 16 j instructions -> instr_cnt wraps 15->0; every JUMP cycle pc_wr=1, pc_src=10.

Source files
------------

// File: rtl/mcycle_ctrl.sv
// Moore-style control FSM for the multi-cycle MIPS-subset CPU: sequences the datapath
// over FETCH..WB, waits on mem_rdy, counts retired instructions, flags illegal opcodes.
module mcycle_ctrl #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             ext_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_ADDIU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILL
  } kind_t;

  state_t state, next_state;
  kind_t  kind;
  logic   retire;
  logic   set_illegal;

  always_comb begin
    kind = K_ILL;
    case (opcode)
      OP_R: begin
        if (funct == FN_ADDU)      kind = K_ADDU;
        else if (funct == FN_SUBU) kind = K_SUBU;
      end
      OP_ADDIU: kind = K_ADDIU;
      OP_ORI:   kind = K_ORI;
      OP_LUI:   kind = K_LUI;
      OP_LW:    kind = K_LW;
      OP_SW:    kind = K_SW;
      OP_BEQ:   kind = K_BEQ;
      OP_J:     kind = K_J;
      default:  kind = K_ILL;
    endcase
  end

  // NOTE: every output and next_state gets a default first so no path infers a latch.
  always_comb begin
    next_state  = state;
    retire      = 1'b0;
    set_illegal = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_wr       = 1'b0;
    pc_src      = 2'b00;
    ir_wr       = 1'b0;
    ext_op      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    alu_op      = ALU_ADD;
    reg_wr      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;

    case (state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_4;
        if (mem_rdy) begin
          pc_wr      = 1'b1;
          ir_wr      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        alu_src_b = SRCB_IMM4;
        ext_op    = 1'b1;
        case (kind)
          K_ADDU, K_SUBU:       next_state = S_EXEC_R;
          K_ADDIU, K_ORI, K_LUI: next_state = S_EXEC_I;
          K_LW, K_SW:           next_state = S_MEM_ADDR;
          K_BEQ:                next_state = S_BRANCH;
          K_J:                  next_state = S_JUMP;
          default: begin
            set_illegal = 1'b1;
            next_state  = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = (kind == K_SUBU) ? ALU_SUB : ALU_ADD;
        next_state = S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        case (kind)
          K_ORI:   alu_op = ALU_OR;
          K_LUI:   alu_op = ALU_LUI;
          default: begin
            ext_op = 1'b1;
            alu_op = ALU_ADD;
          end
        endcase
        next_state = S_WB_I;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        ext_op     = 1'b1;
        next_state = (kind == K_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        if (mem_rdy) next_state = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        if (mem_rdy) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_WB_R: begin
        reg_wr     = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_WB_I: begin
        reg_wr     = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_WB_MEM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_wr      = zero;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_wr      = 1'b1;
        pc_src     = 2'b10;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_HALT;
    endcase
  end

  // NOTE: reset is synchronous and checked first; all state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (set_illegal) illegal <= 1'b1;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: three instances share stimulus (halt on illegal,
// skip illegal, 4-bit counter); per-cycle control words are compared against hand-built constants.
module tb_mcycle_ctrl;

  // Control word layout: mem_rd,mem_wr,pc_wr,pc_src[2],ir_wr,ext_op,alu_src_a,alu_src_b[2],alu_op[3],reg_wr,reg_dst,mem_to_reg
  localparam logic [15:0] W_FETCH_RDY  = 16'b1_0_1_00_1_0_0_01_000_0_0_0;
  localparam logic [15:0] W_FETCH_WAIT = 16'b1_0_0_00_0_0_0_01_000_0_0_0;
  localparam logic [15:0] W_DECODE     = 16'b0_0_0_00_0_1_0_11_000_0_0_0;
  localparam logic [15:0] W_EXR_ADD    = 16'b0_0_0_00_0_0_1_00_000_0_0_0;
  localparam logic [15:0] W_EXR_SUB    = 16'b0_0_0_00_0_0_1_00_001_0_0_0;
  localparam logic [15:0] W_EXI_ADDIU  = 16'b0_0_0_00_0_1_1_10_000_0_0_0;
  localparam logic [15:0] W_EXI_ORI    = 16'b0_0_0_00_0_0_1_10_010_0_0_0;
  localparam logic [15:0] W_EXI_LUI    = 16'b0_0_0_00_0_0_1_10_011_0_0_0;
  localparam logic [15:0] W_MEM_ADDR   = 16'b0_0_0_00_0_1_1_10_000_0_0_0;
  localparam logic [15:0] W_MEM_RD     = 16'b1_0_0_00_0_0_0_00_000_0_0_0;
  localparam logic [15:0] W_MEM_WR     = 16'b0_1_0_00_0_0_0_00_000_0_0_0;
  localparam logic [15:0] W_WB_R       = 16'b0_0_0_00_0_0_0_00_000_1_1_0;
  localparam logic [15:0] W_WB_I       = 16'b0_0_0_00_0_0_0_00_000_1_0_0;
  localparam logic [15:0] W_WB_MEM     = 16'b0_0_0_00_0_0_0_00_000_1_0_1;
  localparam logic [15:0] W_BR_TAKEN   = 16'b0_0_1_01_0_0_1_00_001_0_0_0;
  localparam logic [15:0] W_JUMP       = 16'b0_0_1_10_0_0_0_00_000_0_0_0;
  localparam logic [15:0] W_IDLE       = 16'b0;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011;

  logic clk = 1'b0;
  logic rst_n, zero, mem_rdy;
  logic [5:0] opcode, funct;

  logic [2:0] mem_rd, mem_wr, pc_wr, ir_wr, ext_op, alu_src_a, reg_wr, reg_dst, mem_to_reg, illegal;
  logic [1:0] pc_src [3];
  logic [1:0] alu_src_b [3];
  logic [2:0] alu_op [3];
  logic [31:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  logic [15:0] ctl0, ctl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .pc_wr(pc_wr[0]), .pc_src(pc_src[0]), .ir_wr(ir_wr[0]),
    .ext_op(ext_op[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]),
    .reg_wr(reg_wr[0]), .reg_dst(reg_dst[0]), .mem_to_reg(mem_to_reg[0]), .illegal(illegal[0]),
    .instr_cnt(cnt0));

  mcycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .pc_wr(pc_wr[1]), .pc_src(pc_src[1]), .ir_wr(ir_wr[1]),
    .ext_op(ext_op[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]),
    .reg_wr(reg_wr[1]), .reg_dst(reg_dst[1]), .mem_to_reg(mem_to_reg[1]), .illegal(illegal[1]),
    .instr_cnt(cnt1));

  mcycle_ctrl #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_rd(mem_rd[2]), .mem_wr(mem_wr[2]), .pc_wr(pc_wr[2]), .pc_src(pc_src[2]), .ir_wr(ir_wr[2]),
    .ext_op(ext_op[2]), .alu_src_a(alu_src_a[2]), .alu_src_b(alu_src_b[2]), .alu_op(alu_op[2]),
    .reg_wr(reg_wr[2]), .reg_dst(reg_dst[2]), .mem_to_reg(mem_to_reg[2]), .illegal(illegal[2]),
    .instr_cnt(cnt2));

  assign ctl0 = {mem_rd[0], mem_wr[0], pc_wr[0], pc_src[0], ir_wr[0], ext_op[0], alu_src_a[0],
                 alu_src_b[0], alu_op[0], reg_wr[0], reg_dst[0], mem_to_reg[0]};
  assign ctl1 = {mem_rd[1], mem_wr[1], pc_wr[1], pc_src[1], ir_wr[1], ext_op[1], alu_src_a[1],
                 alu_src_b[1], alu_op[1], reg_wr[1], reg_dst[1], mem_to_reg[1]};

  // Starts and ends on a falling edge; one rising edge sees rst_n low.
  task automatic apply_reset();
    rst_n = 1'b0;
    mem_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    mem_rdy = 1'b0;
    #1;
    checks++; if (ctl0 !== W_FETCH_WAIT) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl0, W_FETCH_WAIT); end
    checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
    checks++; if (illegal[0] !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal[0]); end
    @(negedge clk);
  endtask

  // addu, ori, subu, addiu, lui back to back with memory always ready.
  task automatic test_alu();
    logic [5:0]  o [5];
    logic [5:0]  f [5];
    logic [15:0] e [20];
    o = '{OP_R, OP_ORI, OP_R, OP_ADDIU, OP_LUI};
    f = '{FN_ADDU, 6'd0, FN_SUBU, 6'd0, 6'd0};
    e = '{W_FETCH_RDY, W_DECODE, W_EXR_ADD, W_WB_R,
          W_FETCH_RDY, W_DECODE, W_EXI_ORI, W_WB_I,
          W_FETCH_RDY, W_DECODE, W_EXR_SUB, W_WB_R,
          W_FETCH_RDY, W_DECODE, W_EXI_ADDIU, W_WB_I,
          W_FETCH_RDY, W_DECODE, W_EXI_LUI, W_WB_I};
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      opcode = o[i/4]; funct = f[i/4]; mem_rdy = 1'b1;
      #1;
      checks++; if (ctl0 !== e[i]) begin errors++; $display("FAIL alu_seq[%0d] got=%b exp=%b", i, ctl0, e[i]); end
      if (i == 8) begin
        checks++; if (cnt0 !== 32'd2) begin errors++; $display("FAIL alu_cnt_after_two got=%0d exp=2", cnt0); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (ctl0 !== W_FETCH_RDY) begin errors++; $display("FAIL alu_end_fetch got=%b exp=%b", ctl0, W_FETCH_RDY); end
    checks++; if (cnt0 !== 32'd5) begin errors++; $display("FAIL alu_cnt got=%0d exp=5", cnt0); end
    @(negedge clk);
  endtask

  // lw with three wait cycles in MEM_RD; mem_rdy high in non-memory states must be ignored.
  task automatic test_lw_wait();
    logic [15:0] e [8];
    logic        r [8];
    e = '{W_FETCH_RDY, W_DECODE, W_MEM_ADDR, W_MEM_RD, W_MEM_RD, W_MEM_RD, W_MEM_RD, W_WB_MEM};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    opcode = OP_LW; funct = 6'd0;
    for (int i = 0; i < 8; i++) begin
      mem_rdy = r[i];
      #1;
      checks++; if (ctl0 !== e[i]) begin errors++; $display("FAIL lw_seq[%0d] got=%b exp=%b", i, ctl0, e[i]); end
      @(negedge clk);
    end
    mem_rdy = 1'b0;
    #1;
    checks++; if (ctl0 !== W_FETCH_WAIT) begin errors++; $display("FAIL lw_end_fetch got=%b exp=%b", ctl0, W_FETCH_WAIT); end
    checks++; if (cnt0 !== 32'd1) begin errors++; $display("FAIL lw_cnt got=%0d exp=1", cnt0); end
    @(negedge clk);
  endtask

  // sw after a fetch wait; retires only on the MEM_WR cycle with mem_rdy.
  task automatic test_sw_wait();
    logic [15:0] e [6];
    logic        r [6];
    e = '{W_FETCH_WAIT, W_FETCH_RDY, W_DECODE, W_MEM_ADDR, W_MEM_WR, W_MEM_WR};
    r = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    opcode = OP_SW; funct = 6'd0;
    for (int i = 0; i < 6; i++) begin
      mem_rdy = r[i];
      #1;
      checks++; if (ctl0 !== e[i]) begin errors++; $display("FAIL sw_seq[%0d] got=%b exp=%b", i, ctl0, e[i]); end
      if (i == 5) begin
        checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL sw_cnt_early got=%0d exp=0", cnt0); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (cnt0 !== 32'd1) begin errors++; $display("FAIL sw_cnt got=%0d exp=1", cnt0); end
    @(negedge clk);
  endtask

  // Retire a j, then reset while an lw is stalled in MEM_RD.
  task automatic test_reset_mid_wait();
    logic [15:0] e [8];
    logic        r [8];
    e = '{W_FETCH_RDY, W_DECODE, W_JUMP, W_FETCH_RDY, W_DECODE, W_MEM_ADDR, W_MEM_RD, W_MEM_RD};
    r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 3) ? OP_J : OP_LW; funct = 6'd0; mem_rdy = r[i];
      if (i == 7) rst_n = 1'b0;
      #1;
      checks++; if (ctl0 !== e[i]) begin errors++; $display("FAIL rstwait_seq[%0d] got=%b exp=%b", i, ctl0, e[i]); end
      if (i == 3) begin
        checks++; if (cnt0 !== 32'd1) begin errors++; $display("FAIL rstwait_cnt_pre got=%0d exp=1", cnt0); end
      end
      @(negedge clk);
    end
    rst_n = 1'b1; mem_rdy = 1'b0;
    #1;
    checks++; if (ctl0 !== W_FETCH_WAIT) begin errors++; $display("FAIL rstwait_fetch got=%b exp=%b", ctl0, W_FETCH_WAIT); end
    checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL rstwait_cnt got=%0d exp=0", cnt0); end
    @(negedge clk);
  endtask

  task automatic test_beq();
    apply_reset();
    opcode = OP_BEQ; funct = 6'd0;
    for (int t = 0; t < 2; t++) begin
      zero = (t == 0);
      mem_rdy = 1'b1; #1;
      checks++; if (ctl0 !== W_FETCH_RDY) begin errors++; $display("FAIL beq%0d_fetch got=%b exp=%b", t, ctl0, W_FETCH_RDY); end
      @(negedge clk); mem_rdy = 1'b0; #1;
      checks++; if (ctl0 !== W_DECODE) begin errors++; $display("FAIL beq%0d_decode got=%b exp=%b", t, ctl0, W_DECODE); end
      @(negedge clk); #1;
      if (t == 0) begin
        checks++; if (ctl0 !== W_BR_TAKEN) begin errors++; $display("FAIL beq_taken got=%b exp=%b", ctl0, W_BR_TAKEN); end
      end else begin
        checks++; if (pc_wr[0] !== 1'b0) begin errors++; $display("FAIL beq_not_taken_pc_wr got=%b exp=0", pc_wr[0]); end
        checks++; if (alu_op[0] !== 3'b001) begin errors++; $display("FAIL beq_not_taken_alu got=%b exp=001", alu_op[0]); end
      end
      @(negedge clk);
    end
    zero = 1'b0; #1;
    checks++; if (ctl0 !== W_FETCH_WAIT) begin errors++; $display("FAIL beq_end_fetch got=%b exp=%b", ctl0, W_FETCH_WAIT); end
    checks++; if (cnt0 !== 32'd2) begin errors++; $display("FAIL beq_cnt got=%0d exp=2", cnt0); end
    @(negedge clk);
  endtask

  // dut0 halts on an illegal opcode; dut1 flags it and returns to FETCH without retiring.
  task automatic test_illegal();
    apply_reset();
    opcode = OP_BAD; funct = 6'd0; mem_rdy = 1'b1; #1;
    checks++; if (ctl0 !== W_FETCH_RDY) begin errors++; $display("FAIL ill_fetch got=%b exp=%b", ctl0, W_FETCH_RDY); end
    @(negedge clk); #1;
    checks++; if (ctl0 !== W_DECODE) begin errors++; $display("FAIL ill_decode got=%b exp=%b", ctl0, W_DECODE); end
    checks++; if (illegal[0] !== 1'b0) begin errors++; $display("FAIL ill_flag_early got=%b exp=0", illegal[0]); end
    @(negedge clk);
    mem_rdy = 1'b0; #1;
    checks++; if (ctl1 !== W_FETCH_WAIT) begin errors++; $display("FAIL ill_skip_fetch got=%b exp=%b", ctl1, W_FETCH_WAIT); end
    checks++; if (illegal[1] !== 1'b1) begin errors++; $display("FAIL ill_skip_flag got=%b exp=1", illegal[1]); end
    checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL ill_skip_cnt got=%0d exp=0", cnt1); end
    opcode = OP_J;
    for (int i = 0; i < 20; i++) begin
      mem_rdy = i[0];
      #1;
      checks++; if (ctl0 !== W_IDLE) begin errors++; $display("FAIL halt_ctl[%0d] got=%b exp=%b", i, ctl0, W_IDLE); end
      checks++; if (illegal[0] !== 1'b1) begin errors++; $display("FAIL halt_flag[%0d] got=%b exp=1", i, illegal[0]); end
      @(negedge clk);
    end
    #1;
    checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL halt_cnt got=%0d exp=0", cnt0); end
    @(negedge clk);
  endtask

  // 16 jumps on the 4-bit counter instance: count wraps 15 -> 0.
  task automatic test_wrap();
    apply_reset();
    opcode = OP_J; funct = 6'd0;
    for (int i = 0; i < 16; i++) begin
      mem_rdy = 1'b1; #1;
      checks++; if (cnt2 !== 4'(i)) begin errors++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, cnt2, i); end
      @(negedge clk); mem_rdy = 1'b0;
      @(negedge clk); #1;
      checks++; if (pc_wr[2] !== 1'b1 || pc_src[2] !== 2'b10) begin
        errors++; $display("FAIL wrap_jump[%0d] got=%b/%b exp=1/10", i, pc_wr[2], pc_src[2]);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", cnt2); end
    checks++; if (cnt0 !== 32'd16) begin errors++; $display("FAIL wrap_wide_cnt got=%0d exp=16", cnt0); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; zero = 1'b0; mem_rdy = 1'b0; opcode = 6'd0; funct = 6'd0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_lw_wait();
    test_sw_wait();
    test_reset_mid_wait();
    test_beq();
    test_illegal();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
